instruction_fetch_stage: RTL
============================

// Module: instruction_fetch_stage
// PURPOSE
//  - IF stage of the pipelined MIPS core: owns the PC, drives the instruction memory address and
//    captures the returned word into the IF/ID pipeline register.
//  - Selects the next PC from PC+4, ID-stage j/jal/jr and EX-stage taken branches.
//  - Applies load-use stalls and control-hazard flushes. No branch delay slots.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC value loaded on reset; first fetch address
//  NOP_INSTR  32'h0000_0000  bubble word (sll $0,$0,0) written into IF/ID on flush/reset
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   asynchronous, active-high reset
//  imem_addr       out  32  byte address to instruction memory (= pc); memory indexes [9:2]
//  imem_instr      in   32  instruction word returned combinationally for imem_addr
//  stall           in   1   hazard unit: hold PC and IF/ID (load-use in ID)
//  id_jump         in   1   ID decodes j/jal in ifid_instr
//  id_jr           in   1   ID decodes jr; target on id_jr_addr
//  id_jr_addr      in   32  forwarded rs value for jr
//  ex_branch_taken in   1   EX resolved a taken beq/bne
//  ex_branch_tgt   in   32  EX branch target (pc_plus4 + (sext(imm)<<2))
//  pc              out  32  current fetch PC
//  ifid_instr      out  32  instruction in IF/ID
//  ifid_pc_plus4   out  32  PC+4 of that instruction (link value for jal; branch base)
//  ifid_valid      out  1   0 = bubble
//  misalign_err    out  1   sticky: a redirect target had [1:0] != 0
// BEHAVIOUR
//  - Reset (async): pc = RESET_PC; ifid_instr = NOP_INSTR; ifid_pc_plus4 = 0; ifid_valid = 0;
//    misalign_err = 0. The first fetch after reset release is at RESET_PC.
//  - imem_addr = pc, combinational. The word at pc enters IF/ID at the next rising edge (1-cycle latency).
//  - Jump target: jtgt = {ifid_pc_plus4[31:28], ifid_instr[25:0], 2'b00}.
//  - Next-PC priority, highest first (the older instruction wins):
//    1. ex_branch_taken: pc <= ex_branch_tgt; IF/ID <= bubble. Overrides stall, because the ID
//       instruction is wrong-path.
//    2. stall: pc, ifid_* hold. id_jump and id_jr are ignored this cycle; they are re-evaluated
//       once stall drops.
//    3. id_jr: pc <= id_jr_addr; IF/ID <= bubble.
//    4. id_jump: pc <= jtgt; IF/ID <= bubble.
//    5. Otherwise: pc <= pc + 4; ifid_instr <= imem_instr; ifid_pc_plus4 <= pc + 4; ifid_valid <= 1.
//  - id_jump and id_jr asserted together is illegal decode; jr wins. The bench asserts that it never occurs.
//  - id_jump and id_jr are qualified by ifid_valid internally, so a bubble never redirects.
//  - Redirect targets are loaded with [1:0] forced to 2'b00.
//    misalign_err sets if the raw target had [1:0] != 0, and clears only on reset.
//  - pc + 4 wraps modulo 2^32 without a flag.
//  - Penalties: ID redirect costs 1 bubble. EX branch costs 1 bubble here; flushing the ID
//    instruction is the ID/EX register's job.
//  - Reset asserted mid-stall or mid-redirect: all state goes to reset values immediately;
//    pending redirects are lost.
// STRUCTURE
//  - cpu_defs.vh (shared): NOP_INSTR, opcode/funct constants (OP_J=6'h02, OP_JAL=6'h03,
//    FN_JR=6'h08), RESET_PC.
//  - One sub-module: if_id_reg. Inputs: stall, flush, d_instr, d_pc_plus4.
//    Outputs: the ifid_* registers.
//  - Next-PC mux and PC register stay in the top.
// TESTING
//  1. Reset pulse mid-cycle -> pc=0, ifid_valid=0 asynchronously.
//     After release: imem_addr 0,4,8 on successive cycles; ifid_pc_plus4 = 4,8,12.
//  2. jal 4 at word 2 (32'h0C000004) in ID, id_jump=1 -> next cycle pc=0x10, ifid_valid=0.
//     The cycle after: ifid_instr = word 4, ifid_pc_plus4 = 0x14.
//  3. jr with id_jr_addr=0x0C -> pc=0x0C, one bubble. id_jr_addr=0x0E -> pc=0x0C, misalign_err=1 (sticky).
//  4. stall=1 for 3 cycles with id_jump=1 -> pc and ifid_* frozen.
//     Jump taken on the first cycle after stall drops.
//  5. stall=1 with ex_branch_taken=1, tgt=0x0C (beq self-loop at 0x0C) -> pc=0x0C, bubble.
//     Repeated taken branches hold pc at 0x0C indefinitely.
//  6. ex_branch_taken and id_jump in the same cycle -> pc = ex_branch_tgt; the jump is discarded.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// Shared constants and helpers for the IF stage of the pipelined MIPS core.
package instruction_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;  // sll $0,$0,0

    // Source of the next PC, highest priority first in the selection logic.
    typedef enum logic [2:0] {
        SEL_SEQ    = 3'd0,
        SEL_HOLD   = 3'd1,
        SEL_JR     = 3'd2,
        SEL_JUMP   = 3'd3,
        SEL_BRANCH = 3'd4
    } pc_sel_e;

    // j/jal target: upper nibble of the delay-free PC+4, 26-bit word index, byte offset 0.
    function automatic logic [31:0] jump_target(input logic [3:0]  pc_hi,
                                                input logic [25:0] index);
        return {pc_hi, index, 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads the fetched word, holds on stall, bubbles on flush.
module if_id_reg
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] d_instr,
    input  logic [31:0] d_pc_plus4,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        valid
);

    // Flush beats stall: a flushed ID slot is wrong-path even while the hazard unit holds.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (flush) begin
            instr    <= NOP_INSTR;
            pc_plus4 <= '0;
            valid    <= 1'b0;
        end else if (!stall) begin
            instr    <= d_instr;
            pc_plus4 <= d_pc_plus4;
            valid    <= 1'b1;
        end
    end

endmodule

// File: rtl/instruction_fetch_stage.sv
// IF stage: PC register, next-PC selection, misalignment flag and the IF/ID register.
module instruction_fetch_stage
    import instruction_fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall,
    input  logic        id_jump,
    input  logic        id_jr,
    input  logic [31:0] id_jr_addr,
    input  logic        ex_branch_taken,
    input  logic [31:0] ex_branch_tgt,
    output logic [31:0] pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid,
    output logic        misalign_err
);

    pc_sel_e     pc_sel;
    logic [31:0] pc_plus4;
    logic [31:0] raw_target;
    logic [31:0] next_pc;
    logic        redirect;
    logic        jr_q;
    logic        jump_q;

    assign imem_addr = pc;
    assign pc_plus4  = pc + 32'd4;  // wraps modulo 2^32

    // A bubble in ID carries no real j/jr, so it must never redirect.
    assign jr_q   = id_jr   & ifid_valid;
    assign jump_q = id_jump & ifid_valid;

    // Pick the next-PC source; the older instruction (EX branch) wins over stall and ID redirects.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        pc_sel = SEL_SEQ;
        if (ex_branch_taken) pc_sel = SEL_BRANCH;
        else if (stall)      pc_sel = SEL_HOLD;
        else if (jr_q)       pc_sel = SEL_JR;
        else if (jump_q)     pc_sel = SEL_JUMP;
    end

    // Form the next PC; redirect targets are word-aligned by dropping the low two bits.
    always_comb begin
        raw_target = '0;
        redirect   = 1'b0;
        next_pc    = pc_plus4;
        unique case (pc_sel)
            SEL_BRANCH: begin raw_target = ex_branch_tgt; redirect = 1'b1; end
            SEL_JR:     begin raw_target = id_jr_addr;    redirect = 1'b1; end
            SEL_JUMP:   begin
                raw_target = jump_target(ifid_pc_plus4[31:28], ifid_instr[25:0]);
                redirect   = 1'b1;
            end
            SEL_HOLD:   next_pc = pc;
            default:    next_pc = pc_plus4;
        endcase
        if (redirect) next_pc = {raw_target[31:2], 2'b00};
    end

    // PC register and sticky misalignment flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc           <= RESET_PC;
            misalign_err <= 1'b0;
        end else begin
            pc <= next_pc;
            if (redirect && (raw_target[1:0] != 2'b00)) misalign_err <= 1'b1;
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .flush      (redirect),
        .d_instr    (imem_instr),
        .d_pc_plus4 (pc_plus4),
        .instr      (ifid_instr),
        .pc_plus4   (ifid_pc_plus4),
        .valid      (ifid_valid)
    );

endmodule
